boss_action_sched: RTL and testbench
====================================

# boss_action_sched

Sequencer that decides what the boss does and when. Runs a WAIT → JUMP → SHOOT cycle on `frame_tick`. It arbitrates the target between the two players by aggro. It issues one-cycle jump requests to the boss movement unit and shot pulses to the boss projectile unit. It sits between game state and player logic on one side and the boss datapath blocks on the other.

## Interface
Parameters:
- `WAIT_TICKS`, 40, frame ticks idle on ground between cycles.
- `ENRAGE_WAIT_TICKS`, 20, wait reload while enraged.
- `SHOT_COUNT`, 3, shots per SHOOT phase (1..15).
- `SHOT_GAP`, 12, frame ticks between consecutive shots.
- `ENRAGE_HP`, 8, HP at or below which enrage latches.
- `JUMP_TIMEOUT`, 255, frame ticks allowed in JUMP before forced exit.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-high. Clock is `clk`.
- `frame_tick`  in  1  one-cycle pulse per frame.
- `game_active`  in  2  value 1 = playing. Any other value = not playing.
- `boss_hp`  in  8  current boss HP.
- `boss_x`  in  12  current boss X.
- `char_x`  in  12  player 1 X.
- `player_2_x`  in  12  player 2 X.
- `class_aggro`  in  4  player 1 aggro.
- `player_2_aggro`  in  4  player 2 aggro.
- `player_2_present`  in  1  player 2 connected.
- `jump_done`  in  1  pulse from the movement unit on landing.
- `jump_req`  out  1  one-cycle jump start pulse.
- `jump_dir`  out  1  0 = left, 1 = right. Valid from `jump_req` onward.
- `target_x`  out  12  latched target X.
- `target_sel`  out  1  0 = player 1, 1 = player 2.
- `shot_fire`  out  1  one-cycle shot pulse.
- `shot_dir`  out  1  0 = left, 1 = right. Valid with `shot_fire`.
- `enraged`  out  1  enrage flag.
- `state_dbg`  out  3  encoded FSM state.

## Operation
States and encodings: IDLE=0, WAIT=1, JUMP=2, SHOOT=3, DEAD=4.

Global rules:
- `game_active != 1` in any state → IDLE on the next clk. All counters clear. `enraged` is kept.
- `boss_hp == 0` while `game_active == 1` → DEAD. Takes priority over every other transition.
- DEAD is left only via `rst` or `game_active != 1`.

Transitions:
- IDLE → WAIT when `game_active == 1` and `boss_hp != 0`. `wait_cnt` loads the wait reload value.
- WAIT:
  - On each `frame_tick` with `wait_cnt != 0`, decrement `wait_cnt`.
  - On `frame_tick` with `wait_cnt == 0`, go to JUMP.
  - On that same edge, latch `target_sel`, `target_x` and `jump_dir`.
  - `jump_req` is high for exactly that one following cycle.
- Target arbitration: `target_sel = player_2_present && (player_2_aggro > class_aggro)`. A tie selects player 1.
- `jump_dir = (target_x < boss_x) ? 0 : 1`, computed from the newly selected target.
- JUMP:
  - `jump_done` is sampled from the cycle after `jump_req`.
  - `jump_done` → SHOOT. `shot_cnt` loads the shot count; `gap_cnt` loads 0.
  - `to_cnt` counts frame ticks in JUMP. Reaching `JUMP_TIMEOUT` → WAIT and skips SHOOT.
- SHOOT:
  - On `frame_tick` with `gap_cnt == 0`: pulse `shot_fire`, decrement `shot_cnt`, load `gap_cnt` with `SHOT_GAP`.
  - `shot_dir` is recomputed at each shot from the current `boss_x` against the latched `target_x`.
  - After the last shot, go to WAIT with `wait_cnt` reloaded.
  - On `frame_tick` with `gap_cnt != 0`, decrement `gap_cnt`.
- `jump_done` outside JUMP is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - `jump_req`, `shot_fire`, `shot_dir`, `target_sel`, `enraged` = 0.
  - `jump_dir` = 1.
  - `target_x` = 0.
  - `state_dbg` = 0 (IDLE).
- `jump_req` rises one clk after the qualifying `frame_tick` edge. It never lasts longer than 1 cycle.
- WAIT entry to `jump_req` takes (reload+1) frame ticks.
- First shot fires on the first `frame_tick` after `jump_done`. Shots are then spaced exactly `SHOT_GAP+1` frame ticks apart.
- Simultaneous events, same cycle:
  - `jump_done` and `frame_tick`: the transition to SHOOT is taken. That tick does not fire a shot.
  - `jump_done` and the timeout: `jump_done` wins.
- Counters are 8-bit. Reloads are parameter values and never wrap.
- Reset mid-jump drops the request. The movement unit is reset by the same `rst`.

## Configuration
- Macro `BOSS_SCHED_ENRAGE_EN`.
- Defined:
  - `enraged` sets on the first clk where `0 < boss_hp <= ENRAGE_HP`. It stays set until `rst`.
  - While `enraged`, the WAIT reload is `ENRAGE_WAIT_TICKS`.
  - While `enraged`, the shot count is `SHOT_COUNT+2`.
- Not defined:
  - `enraged` is tied to 0.
  - The reload is always `WAIT_TICKS`.
  - The shot count is always `SHOT_COUNT`.

## Test plan
- Cold start, `game_active=1`, hp=100, `char_x=600`, `boss_x=200` → `jump_req` on the 41st tick after entering WAIT, with `jump_dir=1`, `target_sel=0`, `target_x=600`.
- `player_2_present=1`, `player_2_aggro=5`, `class_aggro=5` → `target_sel=0`. Then `player_2_aggro=6`, `player_2_x=50` → next jump has `target_sel=1`, `jump_dir=0`.
- `jump_done` pulse → 3 `shot_fire` pulses, 13 ticks apart, then WAIT and the next `jump_req` 41 ticks later. A stray `jump_done` in WAIT has no effect.
- No `jump_done` is given → after 255 frame ticks the FSM is back in WAIT and no `shot_fire` pulses.
- hp drops from 100 to 8 mid-SHOOT:
  - With `BOSS_SCHED_ENRAGE_EN`: `enraged=1`, the next wait is 21 ticks and the next SHOOT has 5 shots.
  - Without the macro: timing is unchanged.
- hp=0 during JUMP → DEAD with no pulses. Then `game_active=2` → IDLE. Then `game_active=1` with hp>0 → WAIT restarts. An async `rst` mid-SHOOT clears all outputs within the same cycle.

Source files
------------

// File: rtl/boss_action_sched.sv
// boss_action_sched: frame-tick driven WAIT -> JUMP -> SHOOT boss sequencer with aggro-based targeting.
// Define BOSS_SCHED_ENRAGE_EN to enable the low-HP enrage mode (shorter waits, two extra shots).
module boss_action_sched #(
    parameter int WAIT_TICKS        = 40,
    parameter int ENRAGE_WAIT_TICKS = 20,
    parameter int SHOT_COUNT        = 3,
    parameter int SHOT_GAP          = 12,
    parameter int ENRAGE_HP         = 8,
    parameter int JUMP_TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic [7:0]  boss_hp,
    input  logic [11:0] boss_x,
    input  logic [11:0] char_x,
    input  logic [11:0] player_2_x,
    input  logic [3:0]  class_aggro,
    input  logic [3:0]  player_2_aggro,
    input  logic        player_2_present,
    input  logic        jump_done,
    output logic        jump_req,
    output logic        jump_dir,
    output logic [11:0] target_x,
    output logic        target_sel,
    output logic        shot_fire,
    output logic        shot_dir,
    output logic        enraged,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_JUMP  = 3'd2,
        S_SHOOT = 3'd3,
        S_DEAD  = 3'd4
    } state_t;

    localparam logic [7:0] L_WAIT_RELOAD   = 8'(WAIT_TICKS);
    localparam logic [7:0] L_ENRAGE_RELOAD = 8'(ENRAGE_WAIT_TICKS);
    localparam logic [7:0] L_SHOTS         = 8'(SHOT_COUNT);
    localparam logic [7:0] L_SHOTS_ENRAGED = 8'(SHOT_COUNT + 2);
    localparam logic [7:0] L_GAP           = 8'(SHOT_GAP);
    localparam logic [7:0] L_TO_LAST       = 8'(JUMP_TIMEOUT - 1);
    localparam logic [7:0] L_ENRAGE_HP     = 8'(ENRAGE_HP);
`ifdef BOSS_SCHED_ENRAGE_EN
    localparam logic L_ENRAGE_ON = 1'b1;
`else
    localparam logic L_ENRAGE_ON = 1'b0;
`endif

    state_t      r_state;
    logic [7:0]  r_wait_cnt, r_shot_cnt, r_gap_cnt, r_to_cnt;
    logic        r_jump_req, r_jump_dir, r_target_sel, r_shot_fire, r_shot_dir, r_enraged;
    logic [11:0] r_target_x;

    logic        w_playing, w_sel_p2, w_enrage_hit;
    logic [11:0] w_tgt_x;
    logic [7:0]  w_wait_reload, w_shot_reload;

    // Target arbitration (ties go to player 1) and enrage-dependent reload values.
    always_comb begin
        w_playing     = (game_active == 2'd1);
        w_sel_p2      = player_2_present && (player_2_aggro > class_aggro);
        w_tgt_x       = w_sel_p2 ? player_2_x : char_x;
        w_enrage_hit  = L_ENRAGE_ON && (boss_hp != 8'd0) && (boss_hp <= L_ENRAGE_HP);
        w_wait_reload = r_enraged ? L_ENRAGE_RELOAD : L_WAIT_RELOAD;
        w_shot_reload = r_enraged ? L_SHOTS_ENRAGED : L_SHOTS;
    end

    // Enrage latch: once set it survives game_active drops and only rst clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enraged <= 1'b0;
        end else if (w_enrage_hit) begin
            r_enraged <= 1'b1;
        end
    end

    // Main sequencer; pulse outputs default low so they last one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= 8'd0;
            r_shot_cnt   <= 8'd0;
            r_gap_cnt    <= 8'd0;
            r_to_cnt     <= 8'd0;
            r_jump_req   <= 1'b0;
            r_jump_dir   <= 1'b1;
            r_target_sel <= 1'b0;
            r_target_x   <= 12'd0;
            r_shot_fire  <= 1'b0;
            r_shot_dir   <= 1'b0;
        end else begin
            r_jump_req  <= 1'b0;
            r_shot_fire <= 1'b0;
            if (!w_playing || (boss_hp == 8'd0)) begin
                r_state    <= w_playing ? S_DEAD : S_IDLE;
                r_wait_cnt <= 8'd0;
                r_shot_cnt <= 8'd0;
                r_gap_cnt  <= 8'd0;
                r_to_cnt   <= 8'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= w_wait_reload;
                    end
                    S_WAIT: begin
                        if (frame_tick) begin
                            if (r_wait_cnt != 8'd0) begin
                                r_wait_cnt <= r_wait_cnt - 8'd1;
                            end else begin
                                r_state      <= S_JUMP;
                                r_to_cnt     <= 8'd0;
                                r_jump_req   <= 1'b1;
                                r_target_sel <= w_sel_p2;
                                r_target_x   <= w_tgt_x;
                                r_jump_dir   <= (w_tgt_x < boss_x) ? 1'b0 : 1'b1;
                            end
                        end
                    end
                    S_JUMP: begin
                        // Landing beats a coinciding tick or timeout; ignored while the request is still up.
                        if (jump_done && !r_jump_req) begin
                            r_state    <= S_SHOOT;
                            r_shot_cnt <= w_shot_reload;
                            r_gap_cnt  <= 8'd0;
                            r_to_cnt   <= 8'd0;
                        end else if (frame_tick) begin
                            if (r_to_cnt == L_TO_LAST) begin
                                r_state    <= S_WAIT;
                                r_wait_cnt <= w_wait_reload;
                                r_to_cnt   <= 8'd0;
                            end else begin
                                r_to_cnt <= r_to_cnt + 8'd1;
                            end
                        end
                    end
                    S_SHOOT: begin
                        if (frame_tick) begin
                            if (r_gap_cnt == 8'd0) begin
                                r_shot_fire <= 1'b1;
                                r_shot_dir  <= (r_target_x < boss_x) ? 1'b0 : 1'b1;
                                r_gap_cnt   <= L_GAP;
                                if (r_shot_cnt <= 8'd1) begin
                                    r_state    <= S_WAIT;
                                    r_shot_cnt <= 8'd0;
                                    r_wait_cnt <= w_wait_reload;
                                end else begin
                                    r_shot_cnt <= r_shot_cnt - 8'd1;
                                end
                            end else begin
                                r_gap_cnt <= r_gap_cnt - 8'd1;
                            end
                        end
                    end
                    S_DEAD: begin
                        r_state <= S_DEAD;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign jump_req   = r_jump_req;
    assign jump_dir   = r_jump_dir;
    assign target_x   = r_target_x;
    assign target_sel = r_target_sel;
    assign shot_fire  = r_shot_fire;
    assign shot_dir   = r_shot_dir;
    assign enraged    = r_enraged;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_boss_action_sched.sv
// Self-checking bench for boss_action_sched: target table plus multi-cycle sequences,
// with jump/shot pulses matched against a queue of expected events keyed by frame-tick number.
module tb_boss_action_sched;

`ifdef BOSS_SCHED_ENRAGE_EN
    localparam bit ENR = 1'b1;
`else
    localparam bit ENR = 1'b0;
`endif
    localparam int R_ENR = ENR ? 21 : 41;
    localparam int N_ENR = ENR ? 5 : 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick, jump_done, player_2_present;
    logic [1:0]  game_active;
    logic [7:0]  boss_hp;
    logic [11:0] boss_x, char_x, player_2_x;
    logic [3:0]  class_aggro, player_2_aggro;
    logic        jump_req, jump_dir, target_sel, shot_fire, shot_dir, enraged;
    logic [11:0] target_x;
    logic [2:0]  state_dbg;

    boss_action_sched dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
        .boss_hp(boss_hp), .boss_x(boss_x), .char_x(char_x), .player_2_x(player_2_x),
        .class_aggro(class_aggro), .player_2_aggro(player_2_aggro),
        .player_2_present(player_2_present), .jump_done(jump_done),
        .jump_req(jump_req), .jump_dir(jump_dir), .target_x(target_x),
        .target_sel(target_sel), .shot_fire(shot_fire), .shot_dir(shot_dir),
        .enraged(enraged), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ca, pa;
        logic        pp;
        logic [11:0] cx, px, bx;
        logic        exp_sel;
        logic [11:0] exp_x;
        logic        exp_dir;
    } vec_t;

    typedef struct {
        bit          is_shot;
        int          tick;
        logic        sel;
        logic [11:0] x;
        logic        dir;
    } exp_t;

    vec_t vecs[7];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   tick_no  = 0;
    int   base;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, got, exp, tick_no);
        end
    endtask

    task automatic bad(input string name, input int got, input int exp);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0d expected %0d (tick %0d)", name, got, exp, tick_no);
    endtask

    task automatic expect_jump(input int t, input logic s, input logic [11:0] x, input logic d);
        exp_t e;
        e.is_shot = 1'b0; e.tick = t; e.sel = s; e.x = x; e.dir = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_shot(input int t, input logic d);
        exp_t e;
        e.is_shot = 1'b1; e.tick = t; e.sel = 1'b0; e.x = 12'd0; e.dir = d;
        sb_q.push_back(e);
    endtask

    // slot=1 marks the cycle right after a frame_tick edge, where pulses are due.
    task automatic sample(input bit slot);
        exp_t e;
        if (!rst) begin
            if (jump_req || shot_fire) begin
                if (sb_q.size() == 0) begin
                    bad("unexpected_pulse", int'(shot_fire), 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("pulse_is_shot", int'(shot_fire), int'(e.is_shot));
                    chk("pulse_tick", tick_no, e.tick);
                    chk("pulse_slot", int'(slot), 1);
                    if (e.is_shot) begin
                        chk("shot_dir", int'(shot_dir), int'(e.dir));
                    end else begin
                        chk("jump_target_sel", int'(target_sel), int'(e.sel));
                        chk("jump_target_x", int'(target_x), int'(e.x));
                        chk("jump_dir", int'(jump_dir), int'(e.dir));
                    end
                end
            end else if (sb_q.size() != 0) begin
                if ((sb_q[0].tick < tick_no) || (slot && (sb_q[0].tick == tick_no))) begin
                    e = sb_q.pop_front();
                    bad(e.is_shot ? "missed_shot" : "missed_jump", tick_no, e.tick);
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample(1'b0);
    endtask

    task automatic tick(input bit with_done);
        step();
        frame_tick = 1'b1;
        jump_done  = with_done;
        tick_no++;
        @(negedge clk);
        sample(1'b1);
        frame_tick = 1'b0;
        jump_done  = 1'b0;
        step();
        step();
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic pulse_done();
        step();
        jump_done = 1'b1;
        step();
        jump_done = 1'b0;
    endtask

    task automatic start_wait();
        step();
        game_active = 2'd0;
        step();
        game_active = 2'd1;
        step();
        chk("enter_wait_state", int'(state_dbg), 1);
    endtask

    initial begin
        vecs[0] = '{4'd0,  4'd0,  1'b0, 12'd600, 12'd50,   12'd200,  1'b0, 12'd600,  1'b1};
        vecs[1] = '{4'd5,  4'd5,  1'b1, 12'd600, 12'd50,   12'd200,  1'b0, 12'd600,  1'b1};
        vecs[2] = '{4'd5,  4'd6,  1'b1, 12'd600, 12'd50,   12'd200,  1'b1, 12'd50,   1'b0};
        vecs[3] = '{4'd5,  4'd9,  1'b0, 12'd600, 12'd50,   12'd200,  1'b0, 12'd600,  1'b1};
        vecs[4] = '{4'd0,  4'd0,  1'b0, 12'd200, 12'd50,   12'd200,  1'b0, 12'd200,  1'b1};
        vecs[5] = '{4'd0,  4'd0,  1'b0, 12'd199, 12'd50,   12'd200,  1'b0, 12'd199,  1'b0};
        vecs[6] = '{4'd14, 4'd15, 1'b1, 12'd10,  12'd4095, 12'd4094, 1'b1, 12'd4095, 1'b1};

        rst = 1'b1; frame_tick = 1'b0; jump_done = 1'b0; game_active = 2'd0;
        boss_hp = 8'd100; boss_x = 12'd200; char_x = 12'd600; player_2_x = 12'd50;
        class_aggro = 4'd0; player_2_aggro = 4'd0; player_2_present = 1'b0;
        #12;
        chk("rst_jump_req", int'(jump_req), 0);
        chk("rst_shot_fire", int'(shot_fire), 0);
        chk("rst_jump_dir", int'(jump_dir), 1);
        chk("rst_target_x", int'(target_x), 0);
        chk("rst_state", int'(state_dbg), 0);
        chk("rst_enraged", int'(enraged), 0);
        @(negedge clk);
        rst = 1'b0;
        game_active = 2'd1;

        // Target arbitration and direction table, each from a fresh WAIT.
        for (int v = 0; v < 7; v++) begin
            class_aggro = vecs[v].ca; player_2_aggro = vecs[v].pa;
            player_2_present = vecs[v].pp; char_x = vecs[v].cx;
            player_2_x = vecs[v].px; boss_x = vecs[v].bx;
            start_wait();
            expect_jump(tick_no + 41, vecs[v].exp_sel, vecs[v].exp_x, vecs[v].exp_dir);
            do_ticks(41);
            chk("vec_state_jump", int'(state_dbg), 2);
            chk("vec_target_sel", int'(target_sel), int'(vecs[v].exp_sel));
            chk("vec_target_x", int'(target_x), int'(vecs[v].exp_x));
            chk("vec_jump_dir", int'(jump_dir), int'(vecs[v].exp_dir));
        end

        // Shooting with stray jump_done in WAIT and shot_dir recomputed mid-volley.
        class_aggro = 4'd0; player_2_aggro = 4'd0; player_2_present = 1'b0;
        char_x = 12'd600; boss_x = 12'd200;
        start_wait();
        expect_jump(tick_no + 41, 1'b0, 12'd600, 1'b1);
        do_ticks(10);
        pulse_done();
        do_ticks(31);
        do_ticks(2);
        pulse_done();
        chk("shoot_state", int'(state_dbg), 3);
        base = tick_no + 1;
        expect_shot(base, 1'b1);
        do_ticks(1);
        boss_x = 12'd700;
        expect_shot(base + 13, 1'b0);
        expect_shot(base + 26, 1'b0);
        do_ticks(26);
        chk("after_shoot_wait", int'(state_dbg), 1);
        expect_jump(base + 26 + 41, 1'b0, 12'd600, 1'b0);
        do_ticks(41);

        // jump_done coinciding with frame_tick: SHOOT entered, no shot on that tick.
        tick(1'b1);
        chk("done_tick_shoot", int'(state_dbg), 3);
        base = tick_no;
        expect_shot(base + 1, 1'b0);
        expect_shot(base + 14, 1'b0);
        expect_shot(base + 27, 1'b0);
        do_ticks(27);
        chk("done_tick_wait", int'(state_dbg), 1);

        // Jump timeout: back to WAIT after 255 ticks without shots.
        expect_jump(tick_no + 41, 1'b0, 12'd600, 1'b0);
        do_ticks(41);
        do_ticks(254);
        chk("timeout_still_jump", int'(state_dbg), 2);
        do_ticks(1);
        chk("timeout_to_wait", int'(state_dbg), 1);
        expect_jump(tick_no + 41, 1'b0, 12'd600, 1'b0);
        do_ticks(41);

        // HP drops to ENRAGE_HP mid-SHOOT.
        do_ticks(1);
        pulse_done();
        base = tick_no + 1;
        expect_shot(base, 1'b0);
        expect_shot(base + 13, 1'b0);
        expect_shot(base + 26, 1'b0);
        do_ticks(1);
        boss_hp = 8'd8;
        step();
        chk("enraged_flag", int'(enraged), int'(ENR));
        do_ticks(26);
        expect_jump(tick_no + R_ENR, 1'b0, 12'd600, 1'b0);
        do_ticks(R_ENR);
        do_ticks(1);
        pulse_done();
        base = tick_no + 1;
        for (int k = 0; k < N_ENR; k++) expect_shot(base + 13 * k, 1'b0);
        do_ticks(13 * (N_ENR - 1) + 1);
        chk("enrage_volley_wait", int'(state_dbg), 1);

        // hp=0 during JUMP -> DEAD, then IDLE, then restart.
        expect_jump(tick_no + R_ENR, 1'b0, 12'd600, 1'b0);
        do_ticks(R_ENR);
        do_ticks(2);
        boss_hp = 8'd0;
        step();
        chk("dead_state", int'(state_dbg), 4);
        do_ticks(3);
        pulse_done();
        do_ticks(2);
        chk("dead_stays", int'(state_dbg), 4);
        game_active = 2'd2;
        step();
        chk("inactive_idle", int'(state_dbg), 0);
        chk("enraged_kept", int'(enraged), int'(ENR));
        boss_hp = 8'd100;
        game_active = 2'd1;
        step();
        chk("restart_wait", int'(state_dbg), 1);
        expect_jump(tick_no + R_ENR, 1'b0, 12'd600, 1'b0);
        do_ticks(R_ENR);
        do_ticks(1);
        pulse_done();

        // Async reset while a shot pulse is high.
        expect_shot(tick_no + 1, 1'b0);
        step();
        frame_tick = 1'b1;
        tick_no++;
        @(negedge clk);
        sample(1'b1);
        frame_tick = 1'b0;
        chk("shot_before_rst", int'(shot_fire), 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_shot_fire", int'(shot_fire), 0);
        chk("arst_jump_req", int'(jump_req), 0);
        chk("arst_target_x", int'(target_x), 0);
        chk("arst_target_sel", int'(target_sel), 0);
        chk("arst_jump_dir", int'(jump_dir), 1);
        chk("arst_shot_dir", int'(shot_dir), 0);
        chk("arst_enraged", int'(enraged), 0);
        chk("arst_state", int'(state_dbg), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
